// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID register with a single-outstanding imem handshake.
// Optional perf counters are built only when FETCH_PERF_EN is defined.
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [31:0]     NOP      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic [1:0]      PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic [XLEN-1:0] ALUResultE,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic            FetchBusy,
    output logic [31:0]     PerfFetched,
    output logic [31:0]     PerfBubbles
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_e;

    state_e          state_q, state_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic [31:0]     hold_instr_q, hold_instr_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [31:0]     instr_d_q, instr_d_d;
    logic [XLEN-1:0] pc_d_q, pc_d_d;
    logic [XLEN-1:0] pcp4_d_q, pcp4_d_d;
    logic            valid_d_q, valid_d_d;

    logic            redir;
    logic [XLEN-1:0] target;
    logic            avail;
    logic            handoff;
    logic            load_bubble;
    logic [31:0]     src_instr;
    logic [XLEN-1:0] src_pc;

    always_comb begin
        redir  = (PCSrcE == 2'b01) || (PCSrcE == 2'b10);
        target = (PCSrcE == 2'b10) ? (ALUResultE & ~XLEN'(1)) : PCTargetE;
        avail  = ((state_q == S_WAIT) && imem_rvalid && !drop_q) || (state_q == S_HOLD);
        src_instr = (state_q == S_HOLD) ? hold_instr_q : imem_rdata;
        src_pc    = (state_q == S_HOLD) ? hold_pc_q    : pcf_q;
        handoff     = avail && !StallF && !StallD && !redir && !FlushD;
        load_bubble = FlushD || redir || (!StallD && !handoff);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_REQ;
        else     state_q <= state_d;
    end

    // Next-state logic; drop marks an in-flight response as belonging to a stale PC
    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        case (state_q)
            S_REQ: begin
                if (imem_ready) begin
                    state_d = S_WAIT;
                    drop_d  = redir;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    drop_d = 1'b0;
                    if (drop_q || redir || handoff) state_d = S_REQ;
                    else                            state_d = S_HOLD;
                end else if (redir) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redir || handoff) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    // Outputs
    always_comb begin
        imem_req  = (state_q == S_REQ);
        imem_addr = pcf_q;
        FetchBusy = (state_q == S_WAIT);
    end

    always_comb begin
        pcf_d = pcf_q;
        if (redir)        pcf_d = target;
        else if (handoff) pcf_d = pcf_q + XLEN'(4);

        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        if ((state_q == S_WAIT) && avail && !handoff && !redir) begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = pcf_q;
        end

        instr_d_d = instr_d_q;
        pc_d_d    = pc_d_q;
        pcp4_d_d  = pcp4_d_q;
        valid_d_d = valid_d_q;
        if (FlushD || redir || (!StallD && !handoff)) begin
            instr_d_d = NOP;
            pc_d_d    = '0;
            pcp4_d_d  = '0;
            valid_d_d = 1'b0;
        end else if (!StallD) begin
            instr_d_d = src_instr;
            pc_d_d    = src_pc;
            pcp4_d_d  = src_pc + XLEN'(4);
            valid_d_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q       <= 1'b0;
            pcf_q        <= RESET_PC;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            instr_d_q    <= NOP;
            pc_d_q       <= '0;
            pcp4_d_q     <= '0;
            valid_d_q    <= 1'b0;
        end else begin
            drop_q       <= drop_d;
            pcf_q        <= pcf_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            instr_d_q    <= instr_d_d;
            pc_d_q       <= pc_d_d;
            pcp4_d_q     <= pcp4_d_d;
            valid_d_q    <= valid_d_d;
        end
    end

    assign InstrD   = instr_d_q;
    assign PCD      = pc_d_q;
    assign PCPlus4D = pcp4_d_q;
    assign ValidD   = valid_d_q;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_bubbles_q, perf_bubbles_d;

    always_comb begin
        perf_fetched_d = perf_fetched_q + (handoff     ? 32'd1 : 32'd0);
        perf_bubbles_d = perf_bubbles_q + (load_bubble ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_bubbles_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_bubbles_q <= perf_bubbles_d;
        end
    end

    assign PerfFetched = perf_fetched_q;
    assign PerfBubbles = perf_bubbles_q;
`else
    logic unused_perf;
    assign unused_perf = load_bubble;
    assign PerfFetched = '0;
    assign PerfBubbles = '0;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the 5-stage core.
- Owns the PC and drives a variable-latency instruction-memory request/response interface (at most one request outstanding).
- Feeds the decode stage with InstrD/PCD/PCPlus4D.
- Consumes StallF, StallD and FlushD from the hazard unit, and PCSrcE/targets from the execute stage.

Parameters:
XLEN, 32, datapath/address width.
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in InstrD.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
StallF  in  1  freeze PC / hold fetched instruction.
StallD  in  1  hold IF/ID register.
FlushD  in  1  clear IF/ID register to bubble.
PCSrcE  in  2  00 sequential, 01 branch/JAL taken, 10 JALR, 11 treated as 00.
PCTargetE  in  XLEN  branch/JAL target from EX.
ALUResultE  in  XLEN  JALR target from EX; bit0 forced to 0.
imem_req  out  1  request valid.
imem_addr  out  XLEN  request address (=PCF).
imem_ready  in  1  memory accepts request this cycle.
imem_rvalid  in  1  response data valid.
imem_rdata  in  32  instruction word.
InstrD  out  32  decode instruction.
PCD  out  XLEN  PC of InstrD.
PCPlus4D  out  XLEN  PCD+4.
ValidD  out  1  InstrD is a real instruction.
FetchBusy  out  1  high in S_WAIT.
PerfFetched  out  32  perf counter (see Optional Feature).
PerfBubbles  out  32  perf counter (see Optional Feature).

Behaviour:
- Reset (async, rst=1):
  - PCF=RESET_PC, state=S_REQ, drop=0.
  - InstrD=NOP, PCD=0, PCPlus4D=0, ValidD=0.
  - Hold register cleared; counters=0.
- Redirect: redir = PCSrcE==01 or PCSrcE==10.
  - Target: 01 -> PCTargetE; 10 -> {ALUResultE[XLEN-1:1],1'b0}.
  - Redirect overrides StallF: PCF<=target at the next edge.
- FSM:
  - S_REQ: imem_req=1, imem_addr=PCF.
    - On imem_ready: -> S_WAIT. drop<=redir (a request issued in the redirect cycle carries the stale PC).
    - On redir without ready: stay in S_REQ with the new PC.
  - S_WAIT: imem_req=0; wait for imem_rvalid.
    - redir while waiting sets drop.
    - On rvalid with drop=1: discard the data, drop<=0, -> S_REQ.
  - S_HOLD: response parked in the hold register (instr, pc); imem_req=0.
    - redir -> discard, -> S_REQ.
- avail = (S_WAIT & imem_rvalid & !drop) | S_HOLD. Source is imem_rdata in S_WAIT, hold register in S_HOLD.
- Handoff = avail & !StallF & !StallD & !redir & !FlushD. On handoff:
  - InstrD/PCD/PCPlus4D loaded, ValidD<=1.
  - PCF<=PCF+4, -> S_REQ.
- avail but stalled (no redir/flush): capture into hold, -> S_HOLD. PCF unchanged.
- IF/ID register update priority (highest first):
  - FlushD or redir: bubble (InstrD=NOP, ValidD=0, PCD/PCPlus4D=0). Applies even when StallD=1.
  - StallD: hold all D outputs.
  - Handoff: load.
  - Otherwise: bubble.
- Avail with FlushD but no redir: instruction is not lost. It is parked in S_HOLD and offered again once FlushD drops.
- PC arithmetic: modulo 2^XLEN; PCF+4 wraps 0xFFFF_FFFC -> 0.
- Throughput: with 1-cycle memory latency and imem_ready=1, one instruction every 2 cycles. Pipelined requests are out of scope.
- rst asserted mid-transaction: state returns to S_REQ, and any later imem_rvalid arriving in S_REQ is ignored. The memory side must also be reset.

Optional Feature:
FETCH_PERF_EN
- Defined:
  - PerfFetched increments on every handoff.
  - PerfBubbles increments every cycle the IF/ID register loads a bubble.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: both ports tied to 0 and no counter flops are synthesized.

Test Plan:
- Reset -> PCF=0; first cycle imem_req=1, imem_addr=0x0; ValidD=0, InstrD=0x00000013.
- imem_ready=1, rvalid next cycle with rdata=0x00500093 -> next edge InstrD=0x00500093, PCD=0x0, PCPlus4D=0x4, ValidD=1; next request addr 0x4.
- Response 0x00100113 arrives while StallF=StallD=1 for 3 cycles:
  - state S_HOLD, imem_req=0, D outputs held.
  - Edge after release: InstrD=0x00100113.
- PCSrcE=01, PCTargetE=0x100 during S_WAIT; stale rdata returns 2 cycles later -> discarded, ValidD=0, next imem_addr=0x100.
- PCSrcE=10, ALUResultE=0x203 -> next request addr 0x202 (bit0 cleared); D bubble same edge.
- FlushD=1 with StallD=1 -> InstrD=0x00000013, ValidD=0. With FETCH_PERF_EN: PerfBubbles incremented by 1, PerfFetched unchanged.
